pipe_hazard_ctrl: RTL

Parametrised hazard, forwarding and flush controller for the in-order pipeline, replacing the fixed two-source, two-stage hazard logic. It tracks in-flight destination registers in a DEPTH-entry scoreboard and selects the youngest producer's data for each decode-stage source operand. It also inserts load-use bubbles and generates per-stage flush and enable vectors when a branch resolves. It sits between decode and execute, fed by every post-decode stage's result bus.

---
 rtl/pipe_hazard_pkg.sv | 16 +
 rtl/pipe_hazard_ctrl_scoreboard.sv | 47 ++++
 rtl/pipe_hazard_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard / forwarding controller.
// Scoreboard rd field is sized for register addresses up to RD_MAX_W bits.
package pipe_hazard_pkg;

  localparam int unsigned RD_MAX_W = 8;
  localparam int unsigned FWD_RF   = 0;
  localparam int unsigned FL_IF    = 0;
  localparam int unsigned FL_ID    = 1;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                is_load;
  } sb_entry_t;

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// In-flight destination scoreboard: one entry per post-decode stage, shifting
// toward WB every cycle, with a bubble insert and a branch-shadow invalidate.
module pipe_scoreboard
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned IDXW  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  sb_entry_t             ins_i,
  input  logic                  bubble_i,
  input  logic                  inv_en_i,
  input  logic [IDXW-1:0]       inv_idx_i,
  output sb_entry_t [DEPTH-1:0] entries_o
);

  sb_entry_t [DEPTH-1:0] sb_q;
  sb_entry_t [DEPTH-1:0] sb_d;

  // Shift, then kill every post-shift entry at or below the invalidate index.
  always_comb begin
    sb_d    = sb_q;
    sb_d[0] = bubble_i ? '0 : ins_i;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      sb_d[k] = sb_q[k-1];
    end
    if (inv_en_i) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (IDXW'(k) <= inv_idx_i) begin
          sb_d[k].valid = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  assign entries_o = sb_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush controller between decode and execute.
// Define PIPE_FWD_EN for full forwarding; otherwise the block interlocks only.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned RW         = 24,
  parameter int unsigned RAW        = 4,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 1,
  parameter int unsigned BR_STAGE   = 1,
  parameter int unsigned SELW       = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [RAW-1:0]      id_ra,
  input  logic [RAW-1:0]      id_rb,
  input  logic                id_ra_used,
  input  logic                id_rb_used,
  input  logic [RAW-1:0]      id_rd,
  input  logic                id_reg_write,
  input  logic                id_is_load,
  input  logic [RW-1:0]       rf_a,
  input  logic [RW-1:0]       rf_b,
  input  logic [DEPTH*RW-1:0] stage_data,
  input  logic                branch_taken,
  output logic [SELW-1:0]     fwd_sel_a,
  output logic [SELW-1:0]     fwd_sel_b,
  output logic [RW-1:0]       op_a,
  output logic [RW-1:0]       op_b,
  output logic                stall,
  output logic                en_if,
  output logic                en_id,
  output logic [DEPTH+1:0]    flush,
  output logic [15:0]         stall_cnt
);

  localparam int unsigned CNTW = 16;

  sb_entry_t [DEPTH-1:0] sb;
  sb_entry_t             ins;
  logic                  need_a, need_b;
  logic [SELW-1:0]       sel_a, sel_b;
  logic [RW-1:0]         fwd_a, fwd_b;
  logic [CNTW-1:0]       stall_cnt_q, stall_cnt_d;

`ifdef PIPE_FWD_EN
  logic [RW-1:0] stage_w [DEPTH];
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    assign stage_w[g] = stage_data[g*RW +: RW];
  end
`else
  logic unused_stage;
  assign unused_stage = ^{stage_data, 32'(LOAD_STAGE)};
`endif

  always_comb begin
    ins.valid   = id_valid & id_reg_write;
    ins.rd      = RD_MAX_W'(id_rd);
    ins.is_load = id_is_load;
  end

  pipe_scoreboard #(
    .DEPTH (DEPTH),
    .IDXW  (SELW)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .ins_i     (ins),
    .bubble_i  (stall | branch_taken),
    .inv_en_i  (branch_taken),
    .inv_idx_i (SELW'(BR_STAGE)),
    .entries_o (sb)
  );

  // Oldest-to-youngest scan so the lowest matching index is the final winner.
  always_comb begin
    need_a = 1'b0;
    need_b = 1'b0;
    sel_a  = SELW'(FWD_RF);
    sel_b  = SELW'(FWD_RF);
    fwd_a  = rf_a;
    fwd_b  = rf_b;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (sb[k].valid && id_ra_used && (sb[k].rd == RD_MAX_W'(id_ra))) begin
`ifdef PIPE_FWD_EN
        need_a = sb[k].is_load && (k < int'(LOAD_STAGE));
        sel_a  = SELW'(k + 1);
        fwd_a  = stage_w[k];
`else
        need_a = 1'b1;
`endif
      end
      if (sb[k].valid && id_rb_used && (sb[k].rd == RD_MAX_W'(id_rb))) begin
`ifdef PIPE_FWD_EN
        need_b = sb[k].is_load && (k < int'(LOAD_STAGE));
        sel_b  = SELW'(k + 1);
        fwd_b  = stage_w[k];
`else
        need_b = 1'b1;
`endif
      end
    end
  end

  assign fwd_sel_a = sel_a;
  assign fwd_sel_b = sel_b;
  assign op_a      = fwd_a;
  assign op_b      = fwd_b;

  // A taken branch squashes decode anyway, so it overrides any stall.
  assign stall = (need_a | need_b) & ~branch_taken;
  assign en_if = ~stall;
  assign en_id = ~stall;

  always_comb begin
    flush = '0;
    if (branch_taken) begin
      flush[FL_IF] = 1'b1;
      flush[FL_ID] = 1'b1;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (k <= BR_STAGE) begin
          flush[k+2] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
